nettlp_tx_arbiter: RTL and testbench

//  Two-requester round-robin scheduler for the NetTLP Ethernet TX path. Arbitrates between the

---
 rtl/nettlp_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_nettlp_tx_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nettlp_tx_arbiter.sv
// nettlp_tx_arbiter
//   Two-requester round-robin scheduler for the NetTLP Ethernet TX path. Picks either the
//   completion stream (PORT_CPL) or the memory-request stream (PORT_MR). For each granted packet
//   it emits one header-metadata beat (dport, per-stream seq, tstamp), then passes the granted
//   stream's payload beats straight through until tlast. Packets never interleave.
// Ports
//   clk156, sys_rst                  clock, asynchronous active-high reset
//   cpl_t* / mr_t*                   AXI-stream style requester inputs (64b data, 8b keep)
//   hdr_valid/ready, hdr_dport/seq/tstamp   header metadata handshake to the framer
//   out_t*                           payload stream to the framer
//   busy                             high whenever not idle
module nettlp_tx_arbiter #(
  parameter logic [15:0] PORT_CPL = 16'h3000,
  parameter logic [15:0] PORT_MR  = 16'h4000,
  parameter int unsigned SEQ_W    = 10
) (
  input  logic        clk156,
  input  logic        sys_rst,
  input  logic        cpl_tvalid,
  output logic        cpl_tready,
  input  logic [63:0] cpl_tdata,
  input  logic [7:0]  cpl_tkeep,
  input  logic        cpl_tlast,
  input  logic        mr_tvalid,
  output logic        mr_tready,
  input  logic [63:0] mr_tdata,
  input  logic [7:0]  mr_tkeep,
  input  logic        mr_tlast,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [15:0] hdr_dport,
  output logic [15:0] hdr_seq,
  output logic [31:0] hdr_tstamp,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [63:0] out_tdata,
  output logic [7:0]  out_tkeep,
  output logic        out_tlast,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e             state_q, state_d;
  logic               gnt_q, gnt_d;        // 0: completion stream, 1: memory-request stream
  logic               rr_ptr_q, rr_ptr_d;  // stream preferred when both request
  logic [SEQ_W-1:0]   seq_cpl_q, seq_cpl_d;
  logic [SEQ_W-1:0]   seq_mr_q, seq_mr_d;
  logic [31:0]        tstamp_q, tstamp_d;
  logic [15:0]        hdr_dport_q, hdr_dport_d;
  logic [15:0]        hdr_seq_q, hdr_seq_d;
  logic [31:0]        hdr_tstamp_q, hdr_tstamp_d;

  logic               pick;
  logic               in_data;
  logic               gnt_tvalid;
  logic [63:0]        gnt_tdata;
  logic [7:0]         gnt_tkeep;
  logic               gnt_tlast;

  // Granted-stream view, only meaningful in StData.
  always_comb begin
    gnt_tvalid = gnt_q ? mr_tvalid : cpl_tvalid;
    gnt_tdata  = gnt_q ? mr_tdata  : cpl_tdata;
    gnt_tkeep  = gnt_q ? mr_tkeep  : cpl_tkeep;
    gnt_tlast  = gnt_q ? mr_tlast  : cpl_tlast;
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    seq_cpl_d    = seq_cpl_q;
    seq_mr_d     = seq_mr_q;
    tstamp_d     = tstamp_q + 32'd1;
    hdr_dport_d  = hdr_dport_q;
    hdr_seq_d    = hdr_seq_q;
    hdr_tstamp_d = hdr_tstamp_q;
    pick         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpl_tvalid || mr_tvalid) begin
          // Sole requester wins; a tie goes to the round-robin pointer.
          pick         = (cpl_tvalid && mr_tvalid) ? rr_ptr_q : mr_tvalid;
          gnt_d        = pick;
          hdr_dport_d  = pick ? PORT_MR : PORT_CPL;
          hdr_seq_d    = pick ? 16'(seq_mr_q) : 16'(seq_cpl_q);
          hdr_tstamp_d = tstamp_q;
          state_d      = StHdr;
        end
      end
      StHdr: begin
        if (hdr_ready) state_d = StData;
      end
      StData: begin
        if (gnt_tvalid && out_tready && gnt_tlast) begin
          if (gnt_q) seq_mr_d  = seq_mr_q + SEQ_W'(1);
          else       seq_cpl_d = seq_cpl_q + SEQ_W'(1);
          rr_ptr_d = ~gnt_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      gnt_q        <= 1'b0;
      rr_ptr_q     <= 1'b0;
      seq_cpl_q    <= '0;
      seq_mr_q     <= '0;
      tstamp_q     <= '0;
      hdr_dport_q  <= '0;
      hdr_seq_q    <= '0;
      hdr_tstamp_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      seq_cpl_q    <= seq_cpl_d;
      seq_mr_q     <= seq_mr_d;
      tstamp_q     <= tstamp_d;
      hdr_dport_q  <= hdr_dport_d;
      hdr_seq_q    <= hdr_seq_d;
      hdr_tstamp_q <= hdr_tstamp_d;
    end
  end

  // Payload path is a combinational pass-through while in StData; zero otherwise.
  always_comb begin
    in_data    = (state_q == StData);
    out_tvalid = in_data & gnt_tvalid;
    out_tdata  = in_data ? gnt_tdata : '0;
    out_tkeep  = in_data ? gnt_tkeep : '0;
    out_tlast  = in_data & gnt_tlast;
    cpl_tready = in_data & ~gnt_q & out_tready;
    mr_tready  = in_data &  gnt_q & out_tready;
    hdr_valid  = (state_q == StHdr);
    hdr_dport  = hdr_dport_q;
    hdr_seq    = hdr_seq_q;
    hdr_tstamp = hdr_tstamp_q;
    busy       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_nettlp_tx_arbiter.sv
// Self-checking bench for nettlp_tx_arbiter: per-stream source queues feed the requesters,
// expected headers/beats are queued in grant order and compared as the DUT emits them.
module tb_nettlp_tx_arbiter;

  logic        clk156 = 1'b0;
  logic        sys_rst;
  logic        cpl_tvalid, cpl_tready, cpl_tlast;
  logic [63:0] cpl_tdata;
  logic [7:0]  cpl_tkeep;
  logic        mr_tvalid, mr_tready, mr_tlast;
  logic [63:0] mr_tdata;
  logic [7:0]  mr_tkeep;
  logic        hdr_valid, hdr_ready;
  logic [15:0] hdr_dport, hdr_seq;
  logic [31:0] hdr_tstamp;
  logic        out_tvalid, out_tready, out_tlast;
  logic [63:0] out_tdata;
  logic [7:0]  out_tkeep;
  logic        busy;

  nettlp_tx_arbiter dut (
    .clk156     (clk156),
    .sys_rst    (sys_rst),
    .cpl_tvalid (cpl_tvalid),
    .cpl_tready (cpl_tready),
    .cpl_tdata  (cpl_tdata),
    .cpl_tkeep  (cpl_tkeep),
    .cpl_tlast  (cpl_tlast),
    .mr_tvalid  (mr_tvalid),
    .mr_tready  (mr_tready),
    .mr_tdata   (mr_tdata),
    .mr_tkeep   (mr_tkeep),
    .mr_tlast   (mr_tlast),
    .hdr_valid  (hdr_valid),
    .hdr_ready  (hdr_ready),
    .hdr_dport  (hdr_dport),
    .hdr_seq    (hdr_seq),
    .hdr_tstamp (hdr_tstamp),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .busy       (busy)
  );

  always #5 clk156 = ~clk156;

  typedef struct packed {logic [63:0] data; logic [7:0] keep; logic last;} beat_t;
  typedef struct packed {logic [15:0] dport; logic [15:0] seq;} hdr_t;

  beat_t cpl_src[$];
  beat_t mr_src[$];
  beat_t exp_beat[$];
  hdr_t  exp_hdr[$];

  int          checks = 0;
  int          errors = 0;
  int          pkt_id = 0;
  logic [9:0]  seq_cpl_m = '0;
  logic [9:0]  seq_mr_m  = '0;
  logic        cpl_fire = 1'b0;
  logic        mr_fire  = 1'b0;
  logic [31:0] tb_ts;

  // Reference tick counter: counts rising edges since reset release.
  always @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) tb_ts <= '0;
    else         tb_ts <= tb_ts + 32'd1;
  end

  // Requester model: pop a beat after a handshake, present the next one.
  initial begin
    cpl_tvalid = 1'b0; cpl_tdata = '0; cpl_tkeep = '0; cpl_tlast = 1'b0;
    mr_tvalid  = 1'b0; mr_tdata  = '0; mr_tkeep  = '0; mr_tlast  = 1'b0;
    forever begin
      @(posedge clk156);
      #1;
      if (cpl_fire && cpl_src.size() > 0) void'(cpl_src.pop_front());
      if (mr_fire && mr_src.size() > 0) void'(mr_src.pop_front());
      if (cpl_src.size() > 0) begin
        cpl_tvalid = 1'b1;
        {cpl_tdata, cpl_tkeep, cpl_tlast} = cpl_src[0];
      end else begin
        cpl_tvalid = 1'b0;
        {cpl_tdata, cpl_tkeep, cpl_tlast} = '0;
      end
      if (mr_src.size() > 0) begin
        mr_tvalid = 1'b1;
        {mr_tdata, mr_tkeep, mr_tlast} = mr_src[0];
      end else begin
        mr_tvalid = 1'b0;
        {mr_tdata, mr_tkeep, mr_tlast} = '0;
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  logic        in_hdr  = 1'b0;
  logic        have_ts = 1'b0;
  logic [31:0] exp_ts, last_ts;
  hdr_t        mon_h;
  beat_t       mon_b;
  initial begin
    forever begin
      @(negedge clk156);
      cpl_fire = cpl_tvalid && cpl_tready;
      mr_fire  = mr_tvalid && mr_tready;
      if (sys_rst) begin
        in_hdr  = 1'b0;
        have_ts = 1'b0;
      end else begin
        if (hdr_valid) begin
          if (!in_hdr) begin
            in_hdr = 1'b1;
            exp_ts = tb_ts - 32'd1;
          end
          checks++;
          if (hdr_tstamp !== exp_ts) begin
            errors++;
            $display("FAIL hdr_tstamp got %h expected %h", hdr_tstamp, exp_ts);
          end
          if (hdr_ready) begin
            in_hdr = 1'b0;
            checks++;
            if (exp_hdr.size() == 0) begin
              errors++;
              $display("FAIL hdr_unexpected got dport %h seq %h expected none", hdr_dport, hdr_seq);
            end else begin
              mon_h = exp_hdr.pop_front();
              if ({hdr_dport, hdr_seq} !== mon_h) begin
                errors++;
                $display("FAIL hdr_fields got dport %h seq %h expected dport %h seq %h",
                         hdr_dport, hdr_seq, mon_h.dport, mon_h.seq);
              end
            end
            if (have_ts) begin
              checks++;
              if (!(hdr_tstamp > last_ts)) begin
                errors++;
                $display("FAIL tstamp_order got %h expected above %h", hdr_tstamp, last_ts);
              end
            end
            last_ts = hdr_tstamp;
            have_ts = 1'b1;
          end
        end
        if (out_tvalid && out_tready) begin
          checks++;
          if (exp_beat.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected got %h/%h/%b expected none",
                     out_tdata, out_tkeep, out_tlast);
          end else begin
            mon_b = exp_beat.pop_front();
            if ({out_tdata, out_tkeep, out_tlast} !== mon_b) begin
              errors++;
              $display("FAIL beat got %h/%h/%b expected %h/%h/%b", out_tdata, out_tkeep,
                       out_tlast, mon_b.data, mon_b.keep, mon_b.last);
            end
          end
        end
      end
    end
  end

  // Queue one packet on a stream; the first nexp beats (and the header if nexp > 0) are
  // expected on the output. Call in expected grant order.
  task automatic queue_pkt(input bit mr, input int nbeats, input int nexp);
    beat_t bt;
    hdr_t  hh;
    if (nexp > 0) begin
      hh.dport = mr ? 16'h4000 : 16'h3000;
      hh.seq   = {6'b0, (mr ? seq_mr_m : seq_cpl_m)};
      exp_hdr.push_back(hh);
    end
    for (int b = 0; b < nbeats; b++) begin
      bt.data = {(mr ? 8'hB0 : 8'hA0), pkt_id[23:0], b[31:0]};
      bt.keep = 8'(pkt_id + b) | 8'h01;
      bt.last = (b == nbeats - 1);
      if (mr) mr_src.push_back(bt);
      else    cpl_src.push_back(bt);
      if (b < nexp) exp_beat.push_back(bt);
    end
    if (nexp == nbeats) begin
      if (mr) seq_mr_m++;
      else    seq_cpl_m++;
    end
    pkt_id++;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    cpl_src.delete(); mr_src.delete(); exp_hdr.delete(); exp_beat.delete();
    seq_cpl_m = '0;
    seq_mr_m  = '0;
    repeat (2) @(posedge clk156);
    #1 sys_rst = 1'b0;
  endtask

  task automatic wait_idle(output bit ok, input int max_cycles);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk156);
      if (cpl_src.size() == 0 && mr_src.size() == 0 && exp_hdr.size() == 0 &&
          exp_beat.size() == 0 && !busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, hdr_valid, out_tvalid, cpl_tready, mr_tready, out_tlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 000000",
               {busy, hdr_valid, out_tvalid, cpl_tready, mr_tready, out_tlast});
    end
    checks++;
    if ({hdr_dport, hdr_seq, hdr_tstamp} !== 64'h0) begin
      errors++;
      $display("FAIL reset_hdr got %h/%h/%h expected 0", hdr_dport, hdr_seq, hdr_tstamp);
    end
    checks++;
    if ({out_tdata, out_tkeep} !== 72'h0) begin
      errors++;
      $display("FAIL reset_out got %h/%h expected 0", out_tdata, out_tkeep);
    end
    repeat (2) @(posedge clk156);
    #1 sys_rst = 1'b0;
  endtask

  task automatic test_cpl_basic();
    bit ok;
    bit seen;
    queue_pkt(1'b0, 3, 3);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk156);
      if (cpl_tvalid) begin seen = 1'b1; break; end
    end
    @(negedge clk156);
    checks++;
    if (!seen || hdr_valid !== 1'b1) begin
      errors++;
      $display("FAIL hdr_latency got hdr_valid %b expected 1", hdr_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk156);
      if (out_tvalid && out_tready && out_tlast) begin seen = 1'b1; break; end
    end
    @(negedge clk156);
    checks++;
    if (!seen || busy !== 1'b0 || out_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_last got busy %b tvalid %b expected 0 0", busy, out_tvalid);
    end
    wait_idle(ok, 50);
    checks++;
    if (!ok) begin errors++; $display("FAIL cpl_basic_drain got timeout expected idle"); end
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      queue_pkt(1'b0, 2, 2);
      queue_pkt(1'b1, 2, 2);
    end
    wait_idle(ok, 400);
    checks++;
    if (!ok) begin errors++; $display("FAIL fairness_drain got timeout expected idle"); end
  endtask

  task automatic test_hdr_stall();
    bit ok;
    bit seen;
    logic [15:0] s;
    hdr_ready = 1'b0;
    s = {6'b0, seq_cpl_m};
    queue_pkt(1'b0, 2, 2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk156);
      if (hdr_valid) begin seen = 1'b1; break; end
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk156);
      checks++;
      if (!seen || hdr_valid !== 1'b1 || hdr_dport !== 16'h3000 || hdr_seq !== s ||
          cpl_tready !== 1'b0) begin
        errors++;
        $display("FAIL hdr_stall cycle %0d got v %b dport %h seq %h rdy %b expected 1 3000 %h 0",
                 i, hdr_valid, hdr_dport, hdr_seq, cpl_tready, s);
      end
    end
    @(posedge clk156);
    #1 hdr_ready = 1'b1;
    wait_idle(ok, 50);
    checks++;
    if (!ok) begin errors++; $display("FAIL hdr_stall_drain got timeout expected idle"); end
  endtask

  task automatic test_out_backpressure();
    bit ok;
    bit seen;
    queue_pkt(1'b1, 4, 4);
    queue_pkt(1'b0, 1, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk156);
      if (hdr_valid && hdr_ready) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || hdr_dport !== 16'h4000) begin
      errors++;
      $display("FAIL bp_grant got dport %h expected 4000", hdr_dport);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk156);
      #1 out_tready = (i % 2 == 0);
      @(negedge clk156);
      checks++;
      if (cpl_tready !== 1'b0) begin
        errors++;
        $display("FAIL bp_cpl_tready cycle %0d got %b expected 0", i, cpl_tready);
      end
      if (out_tvalid && out_tready && out_tlast) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_tlast got none expected tlast"); end
    @(posedge clk156);
    #1 out_tready = 1'b1;
    wait_idle(ok, 50);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain got timeout expected idle"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    int gap;
    queue_pkt(1'b0, 2, 2);
    queue_pkt(1'b0, 2, 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk156);
      if (hdr_valid) break;
    end
    gap  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk156);
      gap++;
      if (hdr_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || gap != 4) begin
      errors++;
      $display("FAIL b2b_gap got %0d cycles expected 4", gap);
    end
    wait_idle(ok, 50);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_drain got timeout expected idle"); end
  endtask

  task automatic test_seq_wrap();
    bit ok;
    do_reset();
    for (int k = 0; k < 1025; k++) queue_pkt(1'b0, 1, 1);
    wait_idle(ok, 5000);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_drain got timeout expected idle"); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    bit seen;
    queue_pkt(1'b1, 4, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk156);
      if (hdr_valid && hdr_ready) begin seen = 1'b1; break; end
    end
    @(posedge clk156);
    @(posedge clk156);
    #2;
    checks++;
    if (!seen || out_tvalid !== 1'b1 || mr_tready !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_beat2 got v %b r %b expected 1 1", out_tvalid, mr_tready);
    end
    sys_rst = 1'b1;
    #1;
    checks++;
    if ({busy, hdr_valid, out_tvalid, cpl_tready, mr_tready, out_tlast} !== 6'b0 ||
        {out_tdata, out_tkeep} !== 72'h0 || {hdr_dport, hdr_seq, hdr_tstamp} !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %b %h %h %h expected all zero",
               {busy, hdr_valid, out_tvalid, cpl_tready, mr_tready, out_tlast},
               out_tdata, hdr_dport, hdr_tstamp);
    end
    checks++;
    if (exp_beat.size() != 0 || exp_hdr.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_delivered got %0d beats %0d hdrs pending expected 0 0",
               exp_beat.size(), exp_hdr.size());
    end
    mr_src.delete(); exp_beat.delete(); exp_hdr.delete();
    mr_tvalid = 1'b0;
    seq_cpl_m = '0;
    seq_mr_m  = '0;
    @(posedge clk156);
    #1 sys_rst = 1'b0;
    queue_pkt(1'b1, 2, 2);
    wait_idle(ok, 50);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_drain got timeout expected idle"); end
  endtask

  initial begin
    sys_rst    = 1'b1;
    hdr_ready  = 1'b1;
    out_tready = 1'b1;
    test_reset();
    test_cpl_basic();
    test_fairness();
    test_hdr_stall();
    test_out_backpressure();
    test_back_to_back();
    test_seq_wrap();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
